// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed 7-segment scan driver with double-buffered codes.
// Define SEG_BLINK_EN to build the per-digit blink counter and phase.
module seg_scan_mux #(
    parameter int               DIGITS       = 4,
    parameter int               SEG_W        = 7,
    parameter int               SCAN_DIV     = 1,
    parameter logic [SEG_W-1:0] IDLE_PAT     = 7'b0000001,
    parameter int               BLINK_FRAMES = 64
) (
    input  logic                    clk_sc,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flag,
    input  logic                    load,
    input  logic [DIGITS*SEG_W-1:0] code,
    input  logic [DIGITS-1:0]       blank_mask,
    input  logic [DIGITS-1:0]       blink_mask,
    output logic [DIGITS-1:0]       seg_cs_pin,
    output logic [SEG_W-1:0]        seg_data_1_pin,
    output logic                    frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [DIGITS*SEG_W-1:0] r_shadow;
    logic [DIGITS*SEG_W-1:0] r_active;
    logic                    r_pending;

    logic                    w_tick;
    logic                    w_swap;
    logic                    w_dark;
    logic [DIGITS-1:0]       w_onehot;
    logic [DIGITS-1:0]       w_cs;
    logic [SEG_W-1:0]        w_digit;
    logic [SEG_W-1:0]        w_data;

    assign w_tick  = (r_presc == PRESC_MAX);
    assign w_swap  = w_tick && (r_idx == IDX_LAST);
    assign w_digit = r_active[r_idx*SEG_W +: SEG_W];

    always_ff @(posedge clk_sc) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // A load on the swap tick bypasses the shadow so it lands this frame
    always_ff @(posedge clk_sc) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= code;
            end
            if (w_swap) begin
                if (load) begin
                    r_active <= code;
                end else if (r_pending) begin
                    r_active <= r_shadow;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] r_frames;
    logic          r_phase;

    always_ff @(posedge clk_sc) begin
        if (!rst_n) begin
            r_frames <= '0;
            r_phase  <= 1'b0;
        end else if (w_swap) begin
            if (r_frames == FRM_LAST) begin
                r_frames <= '0;
                r_phase  <= ~r_phase;
            end else begin
                r_frames <= r_frames + 1'b1;
            end
        end
    end

    assign w_dark = r_phase & blink_mask[r_idx];
`else
    logic w_unused;
    assign w_unused = (^blink_mask) ^ (BLINK_FRAMES > 0);
    assign w_dark   = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            w_onehot[i] = (r_idx == IW'(i));
        end
    end

    always_comb begin
        w_cs   = '0;
        w_data = '0;
        if (en) begin
            if (!blank_mask[r_idx] && !w_dark) begin
                w_cs   = w_onehot;
                w_data = w_digit;
            end
        end else if (flag) begin
            w_cs   = w_onehot;
            w_data = IDLE_PAT;
        end
    end

    always_ff @(posedge clk_sc) begin
        if (!rst_n) begin
            seg_cs_pin     <= '0;
            seg_data_1_pin <= '0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= w_swap;
            if (w_tick) begin
                seg_cs_pin     <= w_cs;
                seg_data_1_pin <= w_data;
            end
        end
    end

endmodule
